// File: rtl/m_ext_pkg.sv
// Purpose: shared types and constants for the M-extension divide unit.
// Contents: div_op_e (funct3[1:0] encoding), div_state_e (FSM states),
//           iteration count, counter width and the most negative 32-bit integer.
package m_ext_pkg;

   localparam int unsigned DIV_ITERS = 32;
   localparam int unsigned CNT_W     = 6;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// Purpose: one restoring radix-2 division step (shift, trial subtract, restore).
// Ports:
//   rem       in  XLEN+1  partial remainder before the step
//   quot      in  XLEN    dividend bits still to shift in / quotient bits so far
//   divisor   in  XLEN    magnitude of the divisor
//   rem_next  out XLEN+1  partial remainder after the step
//   quot_next out XLEN    quotient register after the step
module div_iter_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] quot,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_next,
   output logic [XLEN-1:0] quot_next
);

   localparam int unsigned RW = XLEN + 1;
   localparam int unsigned SW = XLEN + 2;

   logic [SW-1:0] shifted;
   logic          fits;

   // Bring in the next dividend bit; the trial subtract succeeds when the divisor fits.
   always_comb begin
      shifted   = {rem, quot[XLEN-1]};
      fits      = (shifted >= {2'b00, divisor});
      rem_next  = fits ? RW'(shifted - {2'b00, divisor}) : RW'(shifted);
      quot_next = {quot[XLEN-2:0], fits};
   end

endmodule

// File: rtl/m_div_unit.sv
// Purpose: multicycle RV32M divider (DIV/DIVU/REM/REMU) with divide-by-zero and
//          signed-overflow fast paths, pipeline flush and one-cycle done pulse.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   start    in   request, sampled only in IDLE
//   op       in   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_val  in   dividend
//   rs2_val  in   divisor
//   flush    in   abort; returns to IDLE without a done pulse
//   busy     out  high whenever the unit is not IDLE
//   done     out  one-cycle pulse with result valid
//   result   out  quotient or remainder, held until the next done
module m_div_unit
   import m_ext_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   div_state_e        state_q, state_d;
   div_op_e           op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN:0]     rem_q, rem_d;
   logic [XLEN-1:0]   quot_q, quot_d;
   logic [XLEN-1:0]   dsr_q, dsr_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [XLEN:0]     step_rem;
   logic [XLEN-1:0]   step_quot;

   logic              req_signed, req_rem, req_div0, req_ovf;
   logic [XLEN-1:0]   abs1, abs2;
   logic [XLEN-1:0]   q_fix, r_fix;

   div_iter_step #(.XLEN(XLEN)) u_step (
      .rem       (rem_q),
      .quot      (quot_q),
      .divisor   (dsr_q),
      .rem_next  (step_rem),
      .quot_next (step_quot)
   );

   // Request decode and operand magnitudes for capture in IDLE.
   always_comb begin
      req_signed = ~op[0];
      req_rem    = op[1];
      req_div0   = (rs2_val == '0);
      req_ovf    = req_signed && (rs1_val == XLEN'(INT_MIN)) && (rs2_val == '1);
      abs1       = (req_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
      abs2       = (req_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
   end

   // Sign correction applied to the outcome of the final iteration.
   always_comb begin
      q_fix = qneg_q ? -step_quot : step_quot;
      r_fix = rneg_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      dsr_d    = dsr_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_d = div_op_e'(op);
                  if (req_div0) begin
                     state_d  = DONE;
                     result_d = req_rem ? rs1_val : '1;
                  end else if (req_ovf) begin
                     state_d  = DONE;
                     result_d = req_rem ? '0 : XLEN'(INT_MIN);
                  end else begin
                     state_d = CALC;
                     cnt_d   = '0;
                     rem_d   = '0;
                     quot_d  = abs1;
                     dsr_d   = abs2;
                     qneg_d  = req_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                     rneg_d  = req_signed && rs1_val[XLEN-1];
                  end
               end
            end
            CALC: begin
               rem_d  = step_rem;
               quot_d = step_quot;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                  state_d  = DONE;
                  result_d = ((op_q == REM) || (op_q == REMU)) ? r_fix : q_fix;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         op_q     <= DIV;
         cnt_q    <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         dsr_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         dsr_q    <= dsr_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_m_div_unit.sv
// Purpose: self-checking bench for m_div_unit; directed vectors, flush and reset
//          scenarios, then randomized operations against an arithmetic reference.
module tb_m_div_unit;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [1:0]  op;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_result = 32'h0;

   always #5 clk = ~clk;

   m_div_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V M semantics computed with 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         OP_DIV:  return 32'(sa / sb);
         OP_DIVU: return a / b;
         OP_REM:  return 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   // Edge (start sample = edge 1) on which done is seen.
   function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
      if (b == 32'h0) return 2;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge after done.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int          edge_n;
      int          busy_hi;
      int          exp_lat;
      bit          got;
      bit          held_ok;
      logic [31:0] exp_r;
      exp_r   = ref_result(o, a, b);
      exp_lat = ref_latency(o, a, b);
      start   = 1'b1;
      op      = o;
      rs1_val = a;
      rs2_val = b;
      flush   = 1'b0;
      @(posedge clk);
      edge_n  = 1;
      busy_hi = 0;
      got     = 1'b0;
      held_ok = 1'b1;
      while (!got && edge_n < 100) begin
         @(negedge clk);
         if (busy) busy_hi++;
         if (done) begin
            got = 1'b1;
         end else begin
            if (result !== last_result) held_ok = 1'b0;
            // Noise on the request inputs while busy must not disturb anything.
            start   = 1'($urandom);
            op      = 2'($urandom);
            rs1_val = $urandom;
            rs2_val = $urandom;
            @(posedge clk);
            edge_n++;
         end
      end
      check({tag, "_lat"}, 32'(edge_n + 1), 32'(exp_lat));
      check({tag, "_res"}, result, exp_r);
      check({tag, "_busy"}, 32'(busy_hi), 32'(exp_lat - 1));
      check({tag, "_hold"}, 32'(held_ok), 32'd1);
      start = 1'b0;
      @(negedge clk);
      check({tag, "_post"}, {30'h0, busy, done}, 32'h0);
      check({tag, "_keep"}, result, exp_r);
      last_result = exp_r;
   endtask

   initial begin
      logic [31:0] a, b;
      logic [1:0]  o;
      bit          saw_done;

      rst     = 1'b0;
      start   = 1'b0;
      flush   = 1'b0;
      op      = 2'b00;
      rs1_val = 32'h0;
      rs2_val = 32'h0;
      #3;
      check("reset_state", {busy, done, result[29:0]}, 32'h0);
      check("reset_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_neg");
      run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, "rem_neg");
      run_op(OP_DIVU, 32'd100, 32'd7, "divu");
      run_op(OP_REMU, 32'd100, 32'd7, "remu");
      run_op(OP_DIV,  32'h1234_5678, 32'h0, "div_zero");
      run_op(OP_REMU, 32'h1234_5678, 32'h0, "remu_zero");
      run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");

      // Flush mid-calculation, then an immediate new request.
      start = 1'b1; op = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         saw_done |= done;
         @(posedge clk);
      end
      @(negedge clk);
      saw_done |= done;
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", {30'h0, busy, done}, 32'h0);
      check("flush_nodone", 32'(saw_done), 32'h0);
      check("flush_result", result, last_result);
      run_op(OP_DIVU, 32'd9, 32'd3, "flush_next");

      // Flush and start together: nothing is captured.
      start = 1'b1; flush = 1'b1; op = OP_DIV; rs1_val = 32'd50; rs2_val = 32'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      saw_done = 1'b0;
      check("fs_idle", {31'h0, busy}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         saw_done |= done | busy;
      end
      check("fs_quiet", 32'(saw_done), 32'h0);
      check("fs_result", result, last_result);

      // Reset in the middle of a calculation.
      start = 1'b1; op = OP_DIV; rs1_val = 32'd1234567; rs2_val = 32'd89;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (14) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_flags", {30'h0, busy, done}, 32'h0);
      check("rst_mid_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      last_result = 32'h0;
      run_op(OP_REMU, 32'd10, 32'd4, "rst_remu");

      // Randomized operations biased toward the corner operands.
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         case ($urandom_range(0, 4))
            0:       a = 32'h8000_0000;
            1:       a = 32'($urandom_range(0, 20));
            2:       a = -32'($urandom_range(1, 20));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 9));
            3:       b = -32'($urandom_range(1, 9));
            default: b = $urandom;
         endcase
         run_op(o, a, b, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
